// File: rtl/dsram_pkg.sv
// Shared constants and FSM state type for the data-SRAM responder.
package dsram_pkg;

    localparam int WORD_BYTES = 32'd4;
    localparam int BYTE_W     = 32'd8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;
    localparam int CNT_W      = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dsram_state_e;

endpackage

// File: rtl/dsram_bytewe_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
module dsram_bytewe_array
    import dsram_pkg::*;
#(
    parameter int ADDR_W = 12
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_BYTES-1:0] wr_en,
    input  logic                  rd_en,
    input  logic                  rd_zero,
    input  logic [ADDR_W-1:0]     idx,
    input  logic [WORD_W-1:0]     wr_data,
    output logic [WORD_W-1:0]     rd_data
);

    logic [WORD_W-1:0] mem_r [0:(1 << ADDR_W) - 1];
    logic [WORD_W-1:0] rd_data_r;

    // Byte-lane writes; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        for (int b = 32'd0; b < WORD_BYTES; b++) begin
            if (wr_en[b]) begin
                mem_r[idx][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read register, only loaded by a read so writes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {WORD_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_zero ? {WORD_W{1'b0}} : mem_r[idx];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: byte-writable array with programmable wait states.
// Define DSRAM_RANGE_CHECK_EN to flag and suppress out-of-range accesses.
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        err
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_wait
        $error("dsram_responder: WAIT_CYCLES must be within 0..15");
    end

    dsram_state_e          state_r;
    dsram_state_e          state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [31:0]           req_addr_r;
    logic [31:0]           req_wdata_r;
    logic [3:0]            req_wen_r;
    logic                  commit_s;
    logic                  stall_s;
    logic [31:0]           cmt_addr_s;
    logic [31:0]           cmt_wdata_s;
    logic [3:0]            cmt_wen_s;
    logic [31:0]           offset_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  oor_s;
    logic [3:0]            wr_en_s;
    logic                  rd_en_s;
    logic                  rdata_valid_r;
    logic                  err_r;

    // Handshake: zero-wait builds commit live inputs, otherwise the latched request.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        stall_s     = 1'b0;
        cmt_addr_s  = req_addr_r;
        cmt_wdata_s = req_wdata_r;
        cmt_wen_s   = req_wen_r;
        if (WAIT_CYCLES == 0) begin
            commit_s    = en & ~rst;
            cmt_addr_s  = addr;
            cmt_wdata_s = wdata;
            cmt_wen_s   = wen;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_s = en & ~rst;
                    if (en) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    stall_s = 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        commit_s    = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                // The still-held en belongs to the finished request.
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, wait counter and request latch; reset drops any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_addr_r  <= 32'h0000_0000;
            req_wdata_r <= 32'h0000_0000;
            req_wen_r   <= 4'h0;
        end else begin
            state_r <= state_nxt_s;
            if ((WAIT_CYCLES != 0) && (state_r == ST_IDLE) && en) begin
                cnt_r       <= WAIT_LOAD;
                req_addr_r  <= addr;
                req_wdata_r <= wdata;
                req_wen_r   <= wen;
            end else if (state_r == ST_WAIT) begin
                cnt_r       <= cnt_r - CNT_ONE;
                req_addr_r  <= req_addr_r;
                req_wdata_r <= req_wdata_r;
                req_wen_r   <= req_wen_r;
            end else begin
                cnt_r       <= cnt_r;
                req_addr_r  <= req_addr_r;
                req_wdata_r <= req_wdata_r;
                req_wen_r   <= req_wen_r;
            end
        end
    end

    assign offset_s = cmt_addr_s - BASE_ADDR;
    assign idx_s    = DEPTH_LOG2'(offset_s >> 2);

`ifdef DSRAM_RANGE_CHECK_EN
    localparam logic [32:0] RANGE_END = {1'b0, BASE_ADDR} + (33'd1 << (DEPTH_LOG2 + 2));
    assign oor_s = (cmt_addr_s < BASE_ADDR) || ({1'b0, cmt_addr_s} >= RANGE_END);
`else
    assign oor_s = 1'b0;
`endif

    assign wr_en_s = (commit_s && !oor_s) ? cmt_wen_s : 4'h0;
    assign rd_en_s = commit_s && (cmt_wen_s == 4'h0);

    // Completion pulses for the cycle after the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            rdata_valid_r <= rd_en_s;
            err_r         <= commit_s & oor_s;
        end
    end

    dsram_bytewe_array #(
        .ADDR_W (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .rd_en   (rd_en_s),
        .rd_zero (oor_s),
        .idx     (idx_s),
        .wr_data (cmt_wdata_s),
        .rd_data (rdata)
    );

    assign rdata_valid = rdata_valid_r;
    assign stall       = stall_s;
    assign err         = err_r;

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: three instances (0, 3 and 2 wait states) against a transaction-level model.
module tb_dsram_responder;

    localparam int NI = 3;
    localparam int WAITS  [NI] = '{0, 3, 2};
    localparam int DEPTHS [NI] = '{12, 12, 4};
`ifdef DSRAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_s    [NI];
    logic [3:0]  wen_s   [NI];
    logic [31:0] addr_s  [NI];
    logic [31:0] wdata_s [NI];
    logic [31:0] rdata_s [NI];
    logic        valid_s [NI];
    logic        stall_s [NI];
    logic        err_s   [NI];

    logic        exp_stall [NI];
    logic        exp_valid [NI];
    logic        exp_err   [NI];
    logic [31:0] exp_rdata [NI];
    logic        vnext     [NI];
    logic        enext     [NI];
    logic [31:0] rnext     [NI];
    int          stall_cnt [NI];
    int          valid_cnt [NI];
    int          err_cnt   [NI];
    logic [31:0] mdl_mem [int];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dsram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst), .en(en_s[0]), .wen(wen_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .rdata(rdata_s[0]), .rdata_valid(valid_s[0]), .stall(stall_s[0]), .err(err_s[0]));

    dsram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0000)) u_dut1 (
        .clk(clk), .rst(rst), .en(en_s[1]), .wen(wen_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .rdata(rdata_s[1]), .rdata_valid(valid_s[1]), .stall(stall_s[1]), .err(err_s[1]));

    dsram_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_dut2 (
        .clk(clk), .rst(rst), .en(en_s[2]), .wen(wen_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]),
        .rdata(rdata_s[2]), .rdata_valid(valid_s[2]), .stall(stall_s[2]), .err(err_s[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Model of one committed access: storage update and the pulses it owes next cycle.
    task automatic commit(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        longint      lim;
        int          key;
        bit          oor;
        logic [31:0] cur;
        lim = longint'(4) << DEPTHS[k];
        key = k * 65536 + (int'(a >> 2) & ((1 << DEPTHS[k]) - 1));
        oor = RANGE_EN && (longint'({32'h0, a}) >= lim);
        cur = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0000_0000;
        if (w == 4'h0) begin
            vnext[k] = 1'b1;
            rnext[k] = oor ? 32'h0000_0000 : cur;
        end else if (!oor) begin
            for (int b = 0; b < 4; b++) begin
                if (w[b]) cur[b*8 +: 8] = d[b*8 +: 8];
            end
            mdl_mem[key] = cur;
        end
        enext[k] = oor;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            exp_valid[k] = vnext[k];
            exp_err[k]   = enext[k];
            if (vnext[k]) exp_rdata[k] = rnext[k];
            vnext[k] = 1'b0;
            enext[k] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < NI; k++) begin
            en_s[k]      = 1'b0;
            exp_stall[k] = 1'b0;
        end
        for (int i = 0; i < n; i++) tick();
    endtask

    // One request: stall for N+1 cycles, commit on the last of them, then a DONE cycle; en stays high.
    task automatic access(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en_s[k] = 1'b1; wen_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
        if (WAITS[k] == 0) begin
            exp_stall[k] = 1'b0;
            commit(k, w, a, d);
            tick();
        end else begin
            for (int c = 0; c <= WAITS[k]; c++) begin
                exp_stall[k] = 1'b1;
                if (c == WAITS[k]) commit(k, w, a, d);
                tick();
            end
            exp_stall[k] = 1'b0;
            tick();
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("stall%0d", k), 32'(stall_s[k]), 32'(exp_stall[k]));
            chk($sformatf("valid%0d", k), 32'(valid_s[k]), 32'(exp_valid[k]));
            chk($sformatf("err%0d", k),   32'(err_s[k]),   32'(exp_err[k]));
            chk($sformatf("rdata%0d", k), rdata_s[k], exp_rdata[k]);
            if (stall_s[k]) stall_cnt[k]++;
            if (valid_s[k]) valid_cnt[k]++;
            if (err_s[k])   err_cnt[k]++;
        end
    end

    initial begin
        int s0;
        int v0;
        for (int k = 0; k < NI; k++) begin
            en_s[k] = 1'b0; wen_s[k] = 4'h0; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
            exp_stall[k] = 1'b0; exp_valid[k] = 1'b0; exp_err[k] = 1'b0; exp_rdata[k] = 32'h0;
            vnext[k] = 1'b0; enext[k] = 1'b0; rnext[k] = 32'h0;
            stall_cnt[k] = 0; valid_cnt[k] = 0; err_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Zero wait states: full write, readback, byte-lane merge.
        access(0, 4'hF, 32'h10, 32'hDEAD_BEEF);
        access(0, 4'h0, 32'h10, 32'h0);
        chk("lit_valid0", 32'(valid_s[0]), 32'd1);
        chk("lit_rd0", rdata_s[0], 32'hDEAD_BEEF);
        access(0, 4'hF, 32'h20, 32'h1122_3344);
        access(0, 4'b0010, 32'h20, 32'h0000_AB00);
        access(0, 4'h0, 32'h20, 32'h0);
        chk("lit_bytelane", rdata_s[0], 32'h1122_AB44);
        idle(2);
        chk("lit_nostall0", 32'(stall_cnt[0]), 32'd0);

        // Three wait states: stall length and single commit.
        access(1, 4'hF, 32'h40, 32'h5A5A_5A5A);
        idle(1);
        s0 = stall_cnt[1];
        v0 = valid_cnt[1];
        access(1, 4'h0, 32'h40, 32'h0);
        idle(2);
        chk("lit_stall_len3", 32'(stall_cnt[1] - s0), 32'd4);
        chk("lit_one_commit", 32'(valid_cnt[1] - v0), 32'd1);
        chk("lit_rd3", rdata_s[1], 32'h5A5A_5A5A);

        // Asynchronous reset while a write sits in WAIT.
        en_s[1] = 1'b1; wen_s[1] = 4'hF; addr_s[1] = 32'h40; wdata_s[1] = 32'h1234_5678;
        exp_stall[1] = 1'b1;
        tick();
        #2 rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            exp_stall[k] = 1'b0; exp_valid[k] = 1'b0; exp_err[k] = 1'b0; exp_rdata[k] = 32'h0;
            vnext[k] = 1'b0; enext[k] = 1'b0;
        end
        #1;
        chk("rst_stall_drop", 32'(stall_s[1]), 32'd0);
        chk("rst_valid_drop", 32'(valid_s[1]), 32'd0);
        en_s[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        access(1, 4'h0, 32'h40, 32'h0);
        idle(1);
        chk("lit_rst_nowrite", rdata_s[1], 32'h5A5A_5A5A);

        // Two wait states, back-to-back write then read.
        access(2, 4'hF, 32'h08, 32'h0BAD_F00D);
        access(2, 4'h0, 32'h08, 32'h0);
        idle(1);
        chk("lit_b2b", rdata_s[2], 32'h0BAD_F00D);

        // Address just past the 16-word array: rejected or wrapped onto word 0.
        access(2, 4'hF, 32'h00, 32'hCAFE_F00D);
        access(2, 4'h0, 32'h40, 32'h0);
        idle(1);
`ifdef DSRAM_RANGE_CHECK_EN
        chk("lit_oor_rd", rdata_s[2], 32'h0000_0000);
`else
        chk("lit_wrap_rd", rdata_s[2], 32'hCAFE_F00D);
`endif
        access(2, 4'hF, 32'h40, 32'hBAD0_BAD0);
        access(2, 4'h0, 32'h00, 32'h0);
        idle(1);
`ifdef DSRAM_RANGE_CHECK_EN
        chk("lit_oor_wr", rdata_s[2], 32'hCAFE_F00D);
        chk("lit_err_cnt", 32'(err_cnt[2]), 32'd2);
`else
        chk("lit_wrap_wr", rdata_s[2], 32'hBAD0_BAD0);
        chk("lit_err_cnt", 32'(err_cnt[2]), 32'd0);
`endif
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
